fifo_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter that lets N producers share the write side of one FIFO_mem instance.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/rr_arb_picker.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-side arbiter
// and its round-robin picker.
//   state_t  : arbiter FSM encoding (ST_IDLE / ST_BURST)
//   STALL_W  : width of the optional stall counter
//   clog2    : ceiling log2 for sizing index and counter fields
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int STALL_W = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_picker.sv
// rr_arb_picker: combinational round-robin selector.
// Scans req starting at rr_ptr and wrapping modulo N. It returns the first
// asserted index. found is high when any request is set.
//   req     in  N   request vector
//   rr_ptr  in  PW  highest-priority index for this scan
//   owner   out PW  selected index (0 when found=0)
//   found   out 1   any request present
module rr_arb_picker
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [PW-1:0] owner,
    output logic          found
);

    always_comb begin
        owner = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx -= N;
            if (!found && req[idx]) begin
                owner = PW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets N producers share one
// FIFO write port. Each grant lasts for up to MAX_BURST words. After that,
// priority rotates to the index after the owner. Each burst is followed by
// one IDLE cycle, during which the next owner is picked.
//   clk, rst   clock and asynchronous active-high reset
//   req        per-producer word-valid
//   w_data_in  producer words, slice i = w_data_in[i*B +: B]
//   full       FIFO full flag; the owner keeps its grant while full is high
//   gnt        registered one-hot grant, all zero when there is no owner
//   wr         FIFO write strobe (combinational from gnt, req and full)
//   w_data     owner's word while a grant is held, otherwise 0
//   busy       high while in BURST
//   stall_cnt  saturating count of owner-blocked-by-full cycles
//              (present only when FIFO_ARB_STALL_CNT_EN is defined)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int B         = 4,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*B-1:0]     w_data_in,
    input  logic               full,
    output logic [N-1:0]       gnt,
    output logic               wr,
    output logic [B-1:0]       w_data,
    output logic               busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam int PW = clog2(N);
    localparam int CW = clog2(MAX_BURST) + 1;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick;
    logic          found;
    logic [CW-1:0] burst_cnt;
    logic          owner_req;
    logic          last_word;

    rr_arb_picker #(.N(N), .PW(PW)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .owner  (pick),
        .found  (found)
    );

    // gnt is zero in IDLE, so this also blocks wr outside BURST.
    assign owner_req = |(gnt & req);
    assign wr        = owner_req & ~full;
    assign last_word = (burst_cnt == CW'(MAX_BURST - 1));

    always_comb begin
        w_data = '0;
        if (|gnt) w_data = w_data_in[owner*B +: B];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt       <= {{(N-1){1'b0}}, 1'b1} << pick;
                        owner     <= pick;
                        busy      <= 1'b1;
                        burst_cnt <= '0;
                        state     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // Release on the last word of the burst, or as soon as
                    // the owner withdraws its request. A partial count is
                    // not carried over to the next grant.
                    if (!owner_req || (wr && last_word)) begin
                        gnt       <= '0;
                        busy      <= 1'b0;
                        burst_cnt <= '0;
                        rr_ptr    <= (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
                        state     <= ST_IDLE;
                    end else if (wr) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == ST_BURST && owner_req && full && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int B  = 4;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*B-1:0] w_data_in;
    logic           full;
    logic [N-1:0]   gnt;
    logic           wr;
    logic [B-1:0]   w_data;
    logic           busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]    stall_cnt;
`endif

    fifo_wr_arbiter #(.B(B), .N(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .w_data_in (w_data_in),
        .full      (full),
        .gnt       (gnt),
        .wr        (wr),
        .w_data    (w_data),
        .busy      (busy)
`ifdef FIFO_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: the current owner (-1 when none), the next
    // priority index, and the number of words taken in this grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_words = 0;

    int dut_wr_cnt;
    logic [B-1:0] dut_q[$];
    logic [B-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_words = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; full = 1'b0; w_data_in = '0;
        #1;
        check("reset_gnt", 32'(gnt), 0);
        check("reset_wr", 32'(wr), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_wdata", 32'(w_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus: outputs are checked against the model at the
    // falling edge, then the model advances with the same inputs.
    task automatic model_cycle(input logic [N-1:0] r, input logic [N*B-1:0] d,
                               input logic f, output logic ewr, output int eown);
        logic [N-1:0] e_gnt;
        logic [B-1:0] e_wd;
        req = r; w_data_in = d; full = f;
        @(negedge clk);
        e_gnt = '0; e_wd = '0; ewr = 1'b0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_wd = d[m_owner*B +: B];
            ewr  = r[m_owner] & ~f;
        end
        eown = m_owner;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("wr", 32'(wr), 32'(ewr));
        check("w_data", 32'(w_data), 32'(e_wd));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        if (wr === 1'b1) begin
            dut_wr_cnt++;
            dut_q.push_back(w_data);
        end
        if (ewr) exp_q.push_back(e_wd);
        if (m_owner < 0) begin
            bit got;
            got = 0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!got && r[i]) begin
                    m_owner = i; m_words = 0; got = 1;
                end
            end
        end else begin
            if (ewr) m_words++;
            if (!r[m_owner] || m_words == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] gnt;
        logic         wr;
        logic [B-1:0] wd;
        logic         busy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ewr;
        int   eown;
        logic [N-1:0] gseq[$];
        logic [N-1:0] prev;
        logic [B-1:0] pw[N];
        int   fcnt;
        int   diffs;

        // Owner 1 drops after two words. Owner 3 is then picked with
        // rr_ptr=2. The data slices come from 16'hDCBA.
        tbl[0] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0};
        tbl[1] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 4'hB, 1'b1};
        tbl[2] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 4'hB, 1'b1};
        tbl[3] = '{4'b1000, 1'b0, 4'b0010, 1'b0, 4'hB, 1'b1};
        tbl[4] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0};
        tbl[5] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 4'hD, 1'b1};
        tbl[6] = '{4'b0000, 1'b0, 4'b1000, 1'b0, 4'hD, 1'b1};
        tbl[7] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'h0, 1'b0};

        apply_reset();
        for (int v = 0; v < 8; v++) begin
            req = tbl[v].req; full = tbl[v].full; w_data_in = 16'hDCBA;
            @(negedge clk);
            check($sformatf("tbl%0d_gnt", v), 32'(gnt), 32'(tbl[v].gnt));
            check($sformatf("tbl%0d_wr", v), 32'(wr), 32'(tbl[v].wr));
            check($sformatf("tbl%0d_wdata", v), 32'(w_data), 32'(tbl[v].wd));
            check($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a burst (owner 2, two words taken).
        apply_reset();
        for (int c = 0; c < 3; c++) model_cycle(4'b0100, 16'h1234, 1'b0, ewr, eown);
        rst = 1'b1;
        #1;
        check("midrst_gnt", 32'(gnt), 0);
        check("midrst_wr", 32'(wr), 0);
        check("midrst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        model_cycle(4'b0001, 16'h1234, 1'b0, ewr, eown);
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // All four request continuously, so grants rotate 4 words at a time.
        apply_reset();
        dut_wr_cnt = 0; prev = '0; gseq.delete();
        for (int c = 0; c < 40; c++) begin
            model_cycle(4'b1111, 16'hFEDC, 1'b0, ewr, eown);
            if (gnt != 0 && gnt != prev) gseq.push_back(gnt);
            prev = gnt;
        end
        check("rr_wr_count", 32'(dut_wr_cnt), 32);
        check("rr_ngrants", 32'(gseq.size()), 8);
        check("rr_g0", 32'(gseq.size() > 0 ? gseq[0] : 4'h0), 32'h1);
        check("rr_g1", 32'(gseq.size() > 1 ? gseq[1] : 4'h0), 32'h2);
        check("rr_g2", 32'(gseq.size() > 2 ? gseq[2] : 4'h0), 32'h4);
        check("rr_g3", 32'(gseq.size() > 3 ? gseq[3] : 4'h0), 32'h8);
        check("rr_g4", 32'(gseq.size() > 4 ? gseq[4] : 4'h0), 32'h1);

        // full is high for 3 cycles in the middle of a burst.
        apply_reset();
        dut_wr_cnt = 0;
        for (int c = 0; c < 9; c++)
            model_cycle(4'b0100, 16'h5A5A, (c >= 2 && c <= 4), ewr, eown);
        check("full_burst_words", 32'(dut_wr_cnt), 4);
        model_cycle(4'b0000, 16'h5A5A, 1'b0, ewr, eown);

`ifdef FIFO_ARB_STALL_CNT_EN
        apply_reset();
        model_cycle(4'b0100, 16'h0, 1'b0, ewr, eown);
        for (int c = 0; c < 10; c++) model_cycle(4'b0100, 16'h0, 1'b1, ewr, eown);
        check("stall_cnt10", 32'(stall_cnt), 10);
`endif

        // Random traffic into an 8-deep FIFO model that drains at random.
        apply_reset();
        dut_q.delete(); exp_q.delete(); dut_wr_cnt = 0; fcnt = 0;
        for (int i = 0; i < N; i++) pw[i] = B'($urandom);
        for (int c = 0; c < 600; c++) begin
            logic [N*B-1:0] d;
            logic [N-1:0]   r;
            logic           f;
            for (int i = 0; i < N; i++) d[i*B +: B] = pw[i];
            r = N'($urandom) | N'($urandom);
            f = (fcnt == 8);
            model_cycle(r, d, f, ewr, eown);
            if (ewr) begin
                fcnt++;
                pw[eown] = B'($urandom);
            end
            if (fcnt > 0 && ($urandom % 3 == 0)) fcnt--;
        end
        check("sb_len", 32'(dut_q.size()), 32'(exp_q.size()));
        diffs = 0;
        for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++)
            if (dut_q[i] !== exp_q[i]) diffs++;
        check("sb_data", 32'(diffs), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
